// File: rtl/csr_pkg.sv
// Shared encodings for the scratch CSR bank.
// CSR op, privilege, and context-FSM types.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_RD  = 2'b00,
        CSR_WR  = 2'b01,
        CSR_SET = 2'b10,
        CSR_CLR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [1:0] {
        CTX_IDLE    = 2'b00,
        CTX_SAVE    = 2'b01,
        CTX_RESTORE = 2'b10
    } ctx_state_e;

    localparam logic CPY_SAVE    = 1'b0;
    localparam logic CPY_RESTORE = 1'b1;

    function automatic logic priv_ok(
        input logic [1:0] cur,
        input logic [1:0] min
    );
        return cur >= min;
    endfunction

endpackage

// File: rtl/csr_scratch_ctx_fsm.sv
// Context save/restore sequencer for the scratch bank.
// Walks one channel per cycle; the datapath does the copy.
module csr_scratch_ctx_fsm
    import csr_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctx_save,
    input  logic          ctx_restore,
    input  logic          shadow_vld,
    output logic          start,
    output logic          busy,
    output logic          copy_en,
    output logic          copy_dir,
    output logic          last,
    output logic [IW-1:0] idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    ctx_state_e state;

    // A pulse is taken only in IDLE; save beats restore.
    assign start   = (state == CTX_IDLE)
                   & (ctx_save | (ctx_restore & shadow_vld));
    assign busy    = (state != CTX_IDLE);
    assign copy_en = busy;
    assign last    = busy & (idx == LAST_IDX);

    // State, copy direction and channel index, stopping at NCH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CTX_IDLE;
            idx      <= '0;
            copy_dir <= CPY_SAVE;
        end else begin
            unique case (state)
                CTX_IDLE: begin
                    if (ctx_save) begin
                        state    <= CTX_SAVE;
                        idx      <= '0;
                        copy_dir <= CPY_SAVE;
                    end else if (ctx_restore && shadow_vld) begin
                        state    <= CTX_RESTORE;
                        idx      <= '0;
                        copy_dir <= CPY_RESTORE;
                    end
                end
                CTX_SAVE, CTX_RESTORE: begin
                    if (idx == LAST_IDX) begin
                        state <= CTX_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= CTX_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/csr_scratch_bank.sv
// Bank of per-privilege scratch CSRs with handshaked RMW ops
// and a shadow copy saved/restored one channel per cycle.
module csr_scratch_bank
    import csr_pkg::*;
#(
    parameter int              XLEN    = 64,
    parameter int              NCH     = 2,
    parameter logic [7:0]      CH_PRIV = 8'b01_11,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_valid,
    output logic                csr_ready,
    input  logic [NCH-1:0]      csr_sel,
    input  logic [1:0]          csr_op,
    input  logic [XLEN-1:0]     csr_wdata,
    input  logic [1:0]          priv,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    input  logic                ctx_save,
    input  logic                ctx_restore,
    output logic                shadow_vld,
    output logic [NCH*XLEN-1:0] scratch_q
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [XLEN-1:0] scr [NCH];
    logic [XLEN-1:0] shd [NCH];

    logic          start;
    logic          busy;
    logic          copy_en;
    logic          copy_dir;
    logic          last;
    logic [IW-1:0] idx;

    csr_op_e         op;
    logic            accept;
    logic            sel_ok;
    logic            priv_bad;
    logic            acc_err;
    logic            wr_en;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    csr_scratch_ctx_fsm #(
        .NCH (NCH),
        .IW  (IW)
    ) u_ctx (
        .clk         (clk),
        .rst         (rst),
        .ctx_save    (ctx_save),
        .ctx_restore (ctx_restore),
        .shadow_vld  (shadow_vld),
        .start       (start),
        .busy        (busy),
        .copy_en     (copy_en),
        .copy_dir    (copy_dir),
        .last        (last),
        .idx         (idx)
    );

    assign op = csr_op_e'(csr_op);

    // Stall while sequencing, while a pulse is taken, or on a stuck response.
    assign csr_ready = !rst & !busy & !start
                     & !(rsp_valid & !rsp_ready);
    assign accept    = csr_valid & csr_ready;
    assign acc_err   = !sel_ok | priv_bad;
    assign wr_en     = accept & !acc_err & (op != CSR_RD);

    // Old value and privilege check, valid when sel is one-hot.
    always_comb begin
        sel_ok   = $onehot(csr_sel);
        old_val  = '0;
        priv_bad = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (csr_sel[i]) begin
                old_val = old_val | scr[i];
                if (!priv_ok(priv, CH_PRIV[2*i +: 2]))
                    priv_bad = 1'b1;
            end
        end
    end

    // Result of the requested read-modify-write.
    always_comb begin
        new_val = old_val;
        unique case (1'b1)
            (op == CSR_WR):  new_val = csr_wdata;
            (op == CSR_SET): new_val = old_val | csr_wdata;
            (op == CSR_CLR): new_val = old_val & ~csr_wdata;
            default:         new_val = old_val;
        endcase
    end

    // Live registers: restore copy or accepted CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++)
                scr[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (copy_en && copy_dir == CPY_RESTORE
                    && idx == IW'(i))
                    scr[i] <= shd[i];
                else if (wr_en && csr_sel[i])
                    scr[i] <= new_val;
            end
        end
    end

    // Shadow bank and its valid flag, updated on the final copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++)
                shd[i] <= RST_VAL;
            shadow_vld <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (copy_en && copy_dir == CPY_SAVE
                    && idx == IW'(i))
                    shd[i] <= scr[i];
            end
            if (last)
                shadow_vld <= (copy_dir == CPY_SAVE);
        end
    end

    // Response register: load on accept, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_err ? '0 : old_val;
            rsp_err   <= acc_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Flatten live registers, ch0 in the low bits.
    always_comb begin
        scratch_q = '0;
        for (int i = 0; i < NCH; i++)
            scratch_q[i*XLEN +: XLEN] = scr[i];
    end

endmodule

// File: tb/tb_csr_scratch_bank.sv
// Scoreboard bench for csr_scratch_bank: directed scenarios
// plus randomized ops against an array-based reference model.
module tb_csr_scratch_bank;

    localparam int         XLEN = 64;
    localparam int         NCH  = 2;
    localparam logic [7:0] CHP  = 8'b01_11;

    logic                clk = 1'b0;
    logic                rst;
    logic                csr_valid;
    logic                csr_ready;
    logic [NCH-1:0]      csr_sel;
    logic [1:0]          csr_op;
    logic [XLEN-1:0]     csr_wdata;
    logic [1:0]          priv;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_err;
    logic                ctx_save;
    logic                ctx_restore;
    logic                shadow_vld;
    logic [NCH*XLEN-1:0] scratch_q;

    always #5 clk = ~clk;

    csr_scratch_bank #(
        .XLEN    (XLEN),
        .NCH     (NCH),
        .CH_PRIV (CHP),
        .RST_VAL ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_valid   (csr_valid),
        .csr_ready   (csr_ready),
        .csr_sel     (csr_sel),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .priv        (priv),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ctx_save    (ctx_save),
        .ctx_restore (ctx_restore),
        .shadow_vld  (shadow_vld),
        .scratch_q   (scratch_q)
    );

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } rsp_t;

    rsp_t            exp_q[$];
    logic [XLEN-1:0] m_live [NCH];
    logic [XLEN-1:0] m_shd  [NCH];
    logic            m_svld;

    int checks = 0;
    int passed = 0;

    function automatic void chk(input string name,
                                input logic [XLEN-1:0] act,
                                input logic [XLEN-1:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Reference: legal iff exactly one channel and priv >= its minimum.
    function automatic rsp_t model_op(input logic [NCH-1:0] sel,
                                      input logic [1:0] op,
                                      input logic [XLEN-1:0] wd,
                                      input logic [1:0] pv);
        rsp_t r;
        int   ch = 0;
        int   n  = 0;
        int   minp;
        for (int i = 0; i < NCH; i++)
            if (sel[i]) begin
                n++;
                ch = i;
            end
        minp = int'((CHP >> (2 * ch)) & 8'd3);
        if (n != 1 || int'(pv) < minp) begin
            r.rdata = '0;
            r.err   = 1'b1;
            return r;
        end
        r.rdata = m_live[ch];
        r.err   = 1'b0;
        case (op)
            2'd1:    m_live[ch] = wd;
            2'd2:    m_live[ch] = m_live[ch] | wd;
            2'd3:    m_live[ch] = m_live[ch] & ~wd;
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: every consumed response is checked against the scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL rsp_unexpected: got rdata %h, expected no response",
                         rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic issue(input logic [NCH-1:0] sel,
                         input logic [1:0] op,
                         input logic [XLEN-1:0] wd,
                         input logic [1:0] pv,
                         input bit rnd,
                         output int n);
        csr_sel   = sel;
        csr_op    = op;
        csr_wdata = wd;
        priv      = pv;
        csr_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (csr_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL accept_timeout: csr_ready 0 for %0d cycles, expected 1", n);
                csr_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        exp_q.push_back(model_op(sel, op, wd, pv));
        @(posedge clk); #1;
        csr_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("%s scratch_q ch%0d", tag, i),
                scratch_q[i*XLEN +: XLEN], m_live[i]);
    endtask

    // Pulse from posedge+1; report pulse-cycle csr_ready and stall length.
    task automatic pulse(input bit s, input bit r,
                         output bit pr, output int bc);
        ctx_save    = s;
        ctx_restore = r;
        @(negedge clk);
        pr = csr_ready;
        @(posedge clk); #1;
        ctx_save    = 1'b0;
        ctx_restore = 1'b0;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (csr_ready) break;
            bc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_live[i] = '0;
            m_shd[i]  = '0;
        end
        m_svld = 1'b0;
    endtask

    initial begin
        int n;
        bit pr;
        int bc;
        bit s;
        bit r;
        int exp_bc;

        rst         = 1'b1;
        csr_valid   = 1'b0;
        csr_sel     = '0;
        csr_op      = 2'd0;
        csr_wdata   = '0;
        priv        = 2'b11;
        rsp_ready   = 1'b1;
        ctx_save    = 1'b0;
        ctx_restore = 1'b0;
        model_reset();

        @(posedge clk); #1;
        @(negedge clk);
        chk("reset csr_ready", 64'(csr_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_rdata", rsp_rdata, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        chk("reset shadow_vld", 64'(shadow_vld), 64'd0);
        check_regs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: read, write, read back
        issue(2'b01, 2'd0, 64'd0, 2'b11, 1'b0, n);
        issue(2'b10, 2'd1, 64'hDEAD_BEEF, 2'b11, 1'b0, n);
        issue(2'b10, 2'd0, 64'd0, 2'b11, 1'b0, n);
        check_regs("t1");

        // 2: set/clear back-to-back at full throughput
        issue(2'b01, 2'd1, 64'hF0, 2'b11, 1'b0, n);
        issue(2'b01, 2'd2, 64'h0F, 2'b11, 1'b0, n);
        chk("t2 set accept wait", 64'(n), 64'd0);
        issue(2'b01, 2'd3, 64'h3C, 2'b11, 1'b0, n);
        chk("t2 clr accept wait", 64'(n), 64'd0);
        chk("t2 ch0 value", scratch_q[XLEN-1:0], 64'hC3);
        check_regs("t2");

        // 3: privilege and select errors
        issue(2'b01, 2'd1, 64'h55, 2'b01, 1'b0, n);
        issue(2'b11, 2'd1, 64'h77, 2'b11, 1'b0, n);
        issue(2'b00, 2'd1, 64'h99, 2'b11, 1'b0, n);
        check_regs("t3");
        drain();

        // 4: response backpressure
        rsp_ready = 1'b0;
        issue(2'b10, 2'd0, 64'd0, 2'b11, 1'b0, n);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4 hold csr_ready", 64'(csr_ready), 64'd0);
            chk("t4 hold rsp_valid", 64'(rsp_valid), 64'd1);
            chk("t4 hold rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);
            chk("t4 hold rsp_err", 64'(rsp_err), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        issue(2'b01, 2'd0, 64'd0, 2'b11, 1'b0, n);
        chk("t4 release accept wait", 64'(n), 64'd0);
        drain();

        // 5: save, modify, restore, ignored restore
        issue(2'b01, 2'd1, 64'd1, 2'b11, 1'b0, n);
        issue(2'b10, 2'd1, 64'd2, 2'b11, 1'b0, n);
        drain();
        pulse(1'b1, 1'b0, pr, bc);
        m_shd = m_live; m_svld = 1'b1;
        chk("t5 save pulse ready", 64'(pr), 64'd0);
        chk("t5 save stall", 64'(bc), 64'(NCH));
        chk("t5 save shadow_vld", 64'(shadow_vld), 64'd1);
        issue(2'b01, 2'd1, 64'd9, 2'b11, 1'b0, n);
        drain();
        check_regs("t5 pre-restore");
        pulse(1'b0, 1'b1, pr, bc);
        m_live = m_shd; m_svld = 1'b0;
        chk("t5 restore pulse ready", 64'(pr), 64'd0);
        chk("t5 restore stall", 64'(bc), 64'(NCH));
        chk("t5 restore shadow_vld", 64'(shadow_vld), 64'd0);
        chk("t5 ch0 restored", scratch_q[XLEN-1:0], 64'd1);
        check_regs("t5 restored");
        pulse(1'b0, 1'b1, pr, bc);
        chk("t5 ignored pulse ready", 64'(pr), 64'd1);
        chk("t5 ignored stall", 64'(bc), 64'd0);
        check_regs("t5 ignored");

        // 6: reset inside SAVE, then simultaneous save+restore
        issue(2'b01, 2'd1, 64'hA5, 2'b11, 1'b0, n);
        issue(2'b10, 2'd1, 64'h5A, 2'b11, 1'b0, n);
        drain();
        ctx_save = 1'b1;
        @(posedge clk); #1;
        ctx_save = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t6 rst shadow_vld", 64'(shadow_vld), 64'd0);
        chk("t6 rst csr_ready", 64'(csr_ready), 64'd1);
        chk("t6 rst rsp_valid", 64'(rsp_valid), 64'd0);
        check_regs("t6 rst");
        @(posedge clk); #1;
        pulse(1'b0, 1'b1, pr, bc);
        chk("t6 restore after rst stall", 64'(bc), 64'd0);

        issue(2'b01, 2'd1, 64'h11, 2'b11, 1'b0, n);
        drain();
        pulse(1'b1, 1'b0, pr, bc);
        m_shd = m_live; m_svld = 1'b1;
        issue(2'b01, 2'd1, 64'h22, 2'b11, 1'b0, n);
        drain();
        pulse(1'b1, 1'b1, pr, bc);
        m_shd = m_live; m_svld = 1'b1;
        chk("t6 both stall", 64'(bc), 64'(NCH));
        chk("t6 both shadow_vld", 64'(shadow_vld), 64'd1);
        issue(2'b01, 2'd1, 64'h33, 2'b11, 1'b0, n);
        drain();
        pulse(1'b0, 1'b1, pr, bc);
        m_live = m_shd; m_svld = 1'b0;
        chk("t6 saved value wins", scratch_q[XLEN-1:0], 64'h22);
        check_regs("t6 both");

        // Random ops with random backpressure and occasional ctx pulses
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 24) == 0) begin
                drain();
                s = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                if (s) begin
                    m_shd = m_live; m_svld = 1'b1; exp_bc = NCH;
                end else if (r && m_svld) begin
                    m_live = m_shd; m_svld = 1'b0; exp_bc = NCH;
                end else begin
                    exp_bc = 0;
                end
                pulse(s, r, pr, bc);
                chk("rnd ctx stall", 64'(bc), 64'(exp_bc));
                chk("rnd shadow_vld", 64'(shadow_vld), 64'(m_svld));
                check_regs("rnd ctx");
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            issue(NCH'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  1'b1, n);
            check_regs("rnd op");
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();
        check_regs("final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
